// File: rtl/guineveer_uart_rx_pkg.sv
// Shared constants, types and parity helper for the guineveer UART receiver.
package guineveer_uart_rx_pkg;

  localparam int OVERSAMPLE_DEFAULT   = 16;
  localparam int SAMPLE_POINT_DEFAULT = 8;
  localparam int DATA_BITS            = 8;

  // Number of samples per frame: start + data + [parity] + stop.
  localparam logic [3:0] FRAME_BITS_NOPAR = 4'd10;
  localparam logic [3:0] FRAME_BITS_PAR   = 4'd11;

  typedef struct packed {
    logic frame;
    logic parity;
  } uart_rx_err_t;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_FRAME = 1'b1
  } rx_state_t;

  // True when the data byte plus its parity bit do not match the selected parity.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic par_bit,
                                           input logic odd);
    return ((^{data, par_bit}) != odd);
  endfunction

endpackage

// File: rtl/guineveer_uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module guineveer_uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw line value through the two stages.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer flops, idle-high after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/guineveer_uart_rx.sv
// guineveer UART receiver: 16x oversampled, 8N1/8E1/8O1, LSB first.
// Optional feature macro: GUINEVEER_UART_RX_SYNC_EN (2-flop input synchronizer on rx).
module guineveer_uart_rx
  import guineveer_uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE   = OVERSAMPLE_DEFAULT,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_enable,
  input  logic       tick_baud_x16,
  input  logic       parity_enable,
  input  logic       parity_odd,
  input  logic       rx,
  output logic       tick_baud,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       idle,
  output logic       frame_err,
  output logic       rx_parity_err
);

  localparam int DIV_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] SAMPLE_IDX = DIV_W'(SAMPLE_POINT - 1);

  logic rx_s;

`ifdef GUINEVEER_UART_RX_SYNC_EN
  guineveer_uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx),
    .q_o   (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  rx_state_t            state_q,      state_d;
  logic [DIV_W-1:0]     baud_div_q,   baud_div_d;
  logic [3:0]           bit_cnt_q,    bit_cnt_d;
  // Holds previously sampled bits; the newest sample enters at the MSB.
  logic [DATA_BITS:0]   sreg_q,       sreg_d;
  logic                 par_en_q,     par_en_d;
  logic                 par_odd_q,    par_odd_d;
  logic                 tick_baud_q,  tick_baud_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic [7:0]           rx_data_q,    rx_data_d;
  uart_rx_err_t         err_q,        err_d;

  logic [3:0]           frame_len_s;
  logic [7:0]           data_s;

  // Frame length and byte position depend on the parity setting latched at start.
  always_comb begin
    frame_len_s = par_en_q ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
    data_s      = par_en_q ? sreg_q[7:0] : sreg_q[8:1];
  end

  // Next-state and output decode; state only moves on baud strobes.
  always_comb begin
    state_d     = state_q;
    baud_div_d  = baud_div_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    tick_baud_d = 1'b0;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    err_d       = '{frame: 1'b0, parity: 1'b0};

    if (!rx_enable) begin
      state_d    = RX_IDLE;
      baud_div_d = DIV_ZERO;
      bit_cnt_d  = 4'd0;
      sreg_d     = {(DATA_BITS+1){1'b0}};
      par_en_d   = 1'b0;
      par_odd_d  = 1'b0;
      rx_data_d  = 8'h00;
    end else if (tick_baud_x16) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d    = RX_FRAME;
            baud_div_d = DIV_ONE;
            bit_cnt_d  = parity_enable ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
            par_en_d   = parity_enable;
            par_odd_d  = parity_odd;
          end else begin
            state_d = RX_IDLE;
          end
        end
        RX_FRAME: begin
          baud_div_d = (baud_div_q == DIV_LAST) ? DIV_ZERO : (baud_div_q + DIV_ONE);
          if (baud_div_q == SAMPLE_IDX) begin
            tick_baud_d = 1'b1;
            sreg_d      = {rx_s, sreg_q[DATA_BITS:1]};
            bit_cnt_d   = bit_cnt_q - 4'd1;
            if (bit_cnt_q == frame_len_s) begin
              // A start bit that reads high was noise: drop back to idle.
              state_d = rx_s ? RX_IDLE : RX_FRAME;
            end else if (bit_cnt_q == 4'd1) begin
              state_d      = RX_IDLE;
              rx_valid_d   = 1'b1;
              rx_data_d    = data_s;
              err_d.frame  = ~rx_s;
              err_d.parity = par_en_q & parity_mismatch(data_s, sreg_q[DATA_BITS], par_odd_q);
            end else begin
              state_d = RX_FRAME;
            end
          end else begin
            state_d = RX_FRAME;
          end
        end
        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      baud_div_q  <= DIV_ZERO;
      bit_cnt_q   <= 4'd0;
      sreg_q      <= {(DATA_BITS+1){1'b0}};
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      tick_baud_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      err_q       <= '{frame: 1'b0, parity: 1'b0};
    end else begin
      state_q     <= state_d;
      baud_div_q  <= baud_div_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      tick_baud_q <= tick_baud_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      err_q       <= err_d;
    end
  end

  assign tick_baud     = tick_baud_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign idle          = (state_q == RX_IDLE);
  assign frame_err     = err_q.frame;
  assign rx_parity_err = err_q.parity;

endmodule

// File: tb/tb_guineveer_uart_rx.sv
// Self-checking bench for guineveer_uart_rx: directed spec scenarios plus random frames
// checked against a frame-level scoreboard.
module tb_guineveer_uart_rx;

  logic       clk;
  logic       rst_i;
  logic       rx_enable;
  logic       tick_baud_x16;
  logic       parity_enable;
  logic       parity_odd;
  logic       rx;
  logic       tick_baud;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       idle;
  logic       frame_err;
  logic       rx_parity_err;

  guineveer_uart_rx dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rx_enable     (rx_enable),
    .tick_baud_x16 (tick_baud_x16),
    .parity_enable (parity_enable),
    .parity_odd    (parity_odd),
    .rx            (rx),
    .tick_baud     (tick_baud),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .idle          (idle),
    .frame_err     (frame_err),
    .rx_parity_err (rx_parity_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       expq[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         tick_count  = 0;
  int         valid_count = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  int         tick_period = 4;
  int         tick_phase  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud strobe source: one-clock pulse every tick_period clocks.
  initial begin
    tick_baud_x16 = 1'b0;
    forever begin
      @(negedge clk);
      tick_phase++;
      if (tick_phase >= tick_period) begin
        tick_phase    = 0;
        tick_baud_x16 = 1'b1;
      end else begin
        tick_baud_x16 = 1'b0;
      end
    end
  end

  // Scoreboard: compare every cycle after the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i || !rx_enable) begin
        expq.delete();
        last_data = 8'h00;
        chk("clr_idle", idle, 1);
        chk("clr_valid", rx_valid, 0);
        chk("clr_tick", tick_baud, 0);
        chk("clr_data", rx_data, 8'h00);
        chk("clr_errs", {frame_err, rx_parity_err}, 0);
      end else begin
        if (tick_baud) tick_count++;
        if (rx_valid) begin
          valid_count++;
          last_ferr = frame_err;
          last_perr = rx_parity_err;
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rx_valid: got data %0h expected no frame at %0t", rx_data, $time);
          end else begin
            e = expq.pop_front();
            chk("rx_data", rx_data, e.data);
            chk("frame_err", frame_err, e.ferr);
            chk("parity_err", rx_parity_err, e.perr);
            last_data = e.data;
          end
        end else begin
          chk("err_without_valid", {frame_err, rx_parity_err}, 0);
        end
        chk("rx_data_hold", rx_data, last_data);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_strobe();
    do @(posedge clk); while (tick_baud_x16 !== 1'b1);
  endtask

  // Drive one bit for nstr strobes; called at a negedge, returns at a negedge.
  task automatic send_bit(input logic v, input int nstr, input bit glitch);
    rx = v;
    for (int s = 1; s <= nstr; s++) begin
      wait_strobe();
      @(negedge clk);
      if (glitch && (s == 11 || s == 12)) rx = ~v;
      else rx = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stop, input bit glitch,
                            input bit cfg_wiggle);
    int t0;
    int v0;
    exp_t e;
    t0 = tick_count;
    v0 = valid_count;
    parity_enable = pen;
    parity_odd    = podd;
    send_bit(1'b0, 16, 1'b0);
    if (cfg_wiggle) begin
      parity_enable = ~pen;
      parity_odd    = ~podd;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], 16, glitch);
    if (pen) send_bit(pbit, 16, glitch);
    e.data = d;
    e.ferr = ~stop;
    e.perr = pen & ((^{d, pbit}) != podd);
    expq.push_back(e);
    if (stop) begin
      send_bit(1'b1, 16, 1'b0);
    end else begin
      send_bit(1'b0, 8, 1'b0);
      send_bit(1'b1, 8, 1'b0);
    end
    chk("frame_ticks", tick_count - t0, pen ? 11 : 10);
    chk("frame_valids", valid_count - v0, 1);
    chk("frame_idle", idle, 1);
  endtask

  initial begin
    int t0;
    int v0;
    logic [7:0] d;
    logic pen;
    logic podd;
    logic pbit;
    logic stop;
    rst_i = 1'b1;
    rx_enable = 1'b0;
    rx = 1'b1;
    parity_enable = 1'b0;
    parity_odd = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_idle", idle, 1);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 0);
    rst_i = 1'b0;
    rx_enable = 1'b1;
    repeat (3) @(negedge clk);

    // Plain 8N1 frame.
    send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_data", rx_data, 8'h41);
    chk("t1_errs", {last_ferr, last_perr}, 0);

    // Parity cases with byte 0xA5 (four ones).
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_even_ok", last_perr, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_even_bad", last_perr, 1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_odd_ok", last_perr, 0);

    // Stop bit sampled low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_ferr", last_ferr, 1);
    chk("t3_data", rx_data, 8'h3C);

    // False start: low for 4 strobes only.
    t0 = tick_count;
    v0 = valid_count;
    send_bit(1'b0, 4, 1'b0);
    send_bit(1'b1, 4, 1'b0);
    chk("t4_idle_after_s8", idle, 1);
    send_bit(1'b1, 8, 1'b0);
    chk("t4_ticks", tick_count - t0, 1);
    chk("t4_valids", valid_count - v0, 0);

    // Receiver disabled during d3 of 0xC6, then a clean 0x55.
    v0 = valid_count;
    d = 8'hC6;
    parity_enable = 1'b0;
    send_bit(1'b0, 16, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i], 16, 1'b0);
    send_bit(d[3], 5, 1'b0);
    chk("t5_busy", idle, 0);
    rx_enable = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rx_enable = 1'b1;
    send_bit(1'b1, 20, 1'b0);
    chk("t5_no_valid", valid_count - v0, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_data", rx_data, 8'h55);

    // Back-to-back "Hi\n".
    v0 = valid_count;
    send_frame(8'h48, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_valids", valid_count - v0, 3);
    chk("t6_last", rx_data, 8'h0A);

    // Reset pulse in the middle of a frame.
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    send_bit(1'b0, 6, 1'b0);
    rst_i = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("t6_rst_idle", idle, 1);
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_pulses", {rx_valid, tick_baud, frame_err, rx_parity_err}, 0);
    @(negedge clk);
    rst_i = 1'b0;
    send_bit(1'b1, 20, 1'b0);

    // Random frames: data, parity config, parity bit, stop, glitches, strobe rate.
    for (int n = 0; n < 24; n++) begin
      tick_period = $urandom_range(1, 4);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ((^d) ^ podd);
      stop = ($urandom_range(0, 5) != 0);
      send_bit(1'b1, $urandom_range(0, 12), 1'b0);
      send_frame(d, pen, podd, pbit, stop, 1'($urandom), 1'($urandom));
    end

    send_bit(1'b1, 20, 1'b0);
    chk("pending_expect", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
